// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with decode and operand forwarding
// One-entry valid/ready slot; decoded and forwarded values are captured on handshake.
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        exmem_wr_en,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_wr_en,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_result,
  input  logic        flush,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [3:0]  alu_ctrl,
  output logic [4:0]  shamt,
  output logic [4:0]  rd,
  output logic        reg_write,
  output logic        illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rdf, sh;
  logic [15:0] imm;

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rdf   = instr[15:11];
  assign sh    = instr[10:6];
  assign funct = instr[5:0];
  assign imm   = instr[15:0];

  logic        out_valid_q, out_valid_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [3:0]  alu_ctrl_q, alu_ctrl_d;
  logic [4:0]  shamt_q, shamt_d, rd_q, rd_d;
  logic        reg_write_q, reg_write_d, illegal_q, illegal_d;

  logic [31:0] rs_op, rt_op;
  logic [31:0] dec_a, dec_b;
  logic [3:0]  dec_alu;
  logic [4:0]  dec_sh, dec_rd;
  logic        dec_rw, dec_ill;
  logic        capture;

  // EX/MEM is the younger producer, so it is checked first.
  always_comb begin
    rs_op = rs_data;
    if (rs == 5'd0)                          rs_op = 32'd0;
    else if (exmem_wr_en && exmem_rd == rs)  rs_op = exmem_result;
    else if (memwb_wr_en && memwb_rd == rs)  rs_op = memwb_result;

    rt_op = rt_data;
    if (rt == 5'd0)                          rt_op = 32'd0;
    else if (exmem_wr_en && exmem_rd == rt)  rt_op = exmem_result;
    else if (memwb_wr_en && memwb_rd == rt)  rt_op = memwb_result;
  end

  always_comb begin
    dec_a   = 32'd0;
    dec_b   = 32'd0;
    dec_alu = 4'b0000;
    dec_sh  = 5'd0;
    dec_rd  = 5'd0;
    dec_rw  = 1'b0;
    dec_ill = 1'b0;
    case (op)
      OP_RTYPE: begin
        dec_a  = rs_op;
        dec_b  = rt_op;
        dec_rd = rdf;
        dec_rw = 1'b1;
        case (funct)
          FN_ADD: dec_alu = 4'b0000;
          FN_SUB: dec_alu = 4'b0010;
          FN_AND: dec_alu = 4'b0100;
          FN_NOR: dec_alu = 4'b0101;
          FN_SLL: begin dec_alu = 4'b1010; dec_sh = sh; end
          FN_SRL: begin dec_alu = 4'b1011; dec_sh = sh; end
          default: begin
            dec_a   = 32'd0;
            dec_b   = 32'd0;
            dec_rd  = 5'd0;
            dec_rw  = 1'b0;
            dec_ill = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        dec_a  = rs_op;
        dec_b  = {{16{imm[15]}}, imm};
        dec_rd = rt;
        dec_rw = 1'b1;
      end
      OP_ANDI: begin
        dec_alu = 4'b0100;
        dec_a   = rs_op;
        dec_b   = {16'd0, imm};
        dec_rd  = rt;
        dec_rw  = 1'b1;
      end
      OP_BEQ: begin
        dec_alu = 4'b0010;
        dec_a   = rs_op;
        dec_b   = rt_op;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  assign in_ready = (!out_valid_q || out_ready) && !flush && !reset;
  assign capture  = in_valid && in_ready;

  // Data fields only move on capture so they never go undefined while idle.
  always_comb begin
    out_valid_d = out_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    alu_ctrl_d  = alu_ctrl_q;
    shamt_d     = shamt_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    illegal_d   = illegal_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_valid_d = 1'b1;
      a_d         = dec_a;
      b_d         = dec_b;
      alu_ctrl_d  = dec_alu;
      shamt_d     = dec_sh;
      rd_d        = dec_rd;
      reg_write_d = dec_rw;
      illegal_d   = dec_ill;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      alu_ctrl_q  <= 4'd0;
      shamt_q     <= 5'd0;
      rd_q        <= 5'd0;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      alu_ctrl_q  <= alu_ctrl_d;
      shamt_q     <= shamt_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign a         = a_q;
  assign b         = b_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign shamt     = shamt_q;
  assign rd        = rd_q;
  assign reg_write = reg_write_q;
  assign illegal   = illegal_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high, sampled on clk rising edge.
REQ-003 SHALL have ports: in_valid in 1 / in_ready out 1  upstream handshake; instr in 32  instruction word; rs_data, rt_data in 32  register-file read data.
REQ-004 SHALL have ports: exmem_wr_en in 1, exmem_rd in 5, exmem_result in 32; memwb_wr_en in 1, memwb_rd in 5, memwb_result in 32  forwarding sources.
REQ-005 SHALL have ports: flush in 1  squash held/incoming instruction; out_ready in 1  downstream accept.
REQ-006 SHALL have ports: out_valid out 1; a, b out 32  ALU operands; alu_ctrl out 4; shamt out 5; rd out 5  destination register; reg_write out 1; illegal out 1. All outputs SHALL be registered.

Function
REQ-007 SHALL decode fields: op=instr[31:26], rs=[25:21], rt=[20:16], rdf=[15:11], sh=[10:6], funct=[5:0], imm=[15:0].
REQ-008 SHALL map op 000000 by funct: 100000 add->0000, 100010 sub->0010, 100100 and->0100, 100111 nor->0101, 000000 sll->1010, 000010 srl->1011; rd=rdf, reg_write=1, b=rt operand.
REQ-009 SHALL map addi (001000): alu_ctrl 0000, b=sign-extended imm; andi (001100): alu_ctrl 0100, b=zero-extended imm; both rd=rt, reg_write=1.
REQ-010 SHALL map beq (000100): alu_ctrl 0010, b=rt operand, rd=0, reg_write=0.
REQ-011 Any other op/funct SHALL produce illegal=1, alu_ctrl 0000, a=b=0, shamt=0, rd=0, reg_write=0; out_valid still asserted.
REQ-012 shamt SHALL equal sh for sll/srl, 0 otherwise; a SHALL be rs operand for all legal instructions.
REQ-013 Operand select per source register r: r==0 -> 0; else exmem_wr_en && exmem_rd==r -> exmem_result; else memwb_wr_en && memwb_rd==r -> memwb_result; else rs_data/rt_data. EX/MEM SHALL win when both match.
REQ-014 in_ready SHALL be combinational: (!out_valid || out_ready) && !flush.
REQ-015 Capture SHALL occur on a clk edge with in_valid && in_ready; decoded/forwarded values registered; out_valid=1 next cycle (latency 1 cycle).
REQ-016 With out_valid=1 and out_ready=0, all outputs SHALL hold stable.
REQ-017 With out_valid=1, out_ready=1 and no capture, out_valid SHALL clear next cycle; with capture, new contents replace old back-to-back (full throughput).
REQ-018 flush=1 SHALL clear out_valid next cycle, block capture that cycle, and take priority over out_ready and in_valid.
REQ-019 Data outputs SHALL be don't-care-free: when out_valid=0 they retain last value (zero after reset).

Reset
REQ-020 reset=1 SHALL, at the next clk edge, set out_valid=0, a=b=0, alu_ctrl=0000, shamt=0, rd=0, reg_write=0, illegal=0.
REQ-021 reset SHALL override flush and capture; an instruction held mid-stall SHALL be discarded.
REQ-022 in_ready SHALL be 0 while reset=1.

Verification
REQ-023 Reset: assert reset 2 cycles, in_valid=1 -> out_valid=0, all outputs 0, in_ready=0.
REQ-024 Add: instr 0x00221820, rs_data=5, rt_data=7, no forwarding -> next cycle out_valid=1, a=5, b=7, alu_ctrl=0000, rd=3, reg_write=1, illegal=0.
REQ-025 Addi/sll: instr 0x2024FFFF, rs_data=9 -> a=9, b=0xFFFFFFFF, rd=4; then instr 0x00022900, rt_data=0x3 -> a=0, b=3, shamt=4, alu_ctrl=1010, rd=5.
REQ-026 Forwarding: add 0x00221820 with exmem_rd=1/0x10, memwb_rd=1/0x20, memwb_rd=2 (second source) /0x30 via alternating cycles -> a=0x10 (EX/MEM priority), b=0x30; exmem_rd=0 with wr_en=1 -> no forward.
REQ-027 Stall/flush: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged; flush=1 with in_valid=1 -> out_valid=0 next cycle, no capture; then out_ready=1 -> back-to-back captures each cycle.
REQ-028 Illegal: instr 0xFC000000 -> out_valid=1, illegal=1, reg_write=0, a=b=0.
